// File: rtl/txgen.sv
// -----------------------------------------------------------------------------
// txgen - bus response frame generator
//
// On each read request from the receive parser, txgen fetches one 32-bit
// sensor value from the sensor data store. It then serialises a 12-byte
// response frame into a byte-level UART transmitter, one byte at a time:
//
//   idx  0..1  DEV_ID, MSB first
//   idx  2..3  byte count 16'h0008, MSB first
//   idx  4     sensor ID
//   idx  5     status (8'h03 data OK, 8'hEE store timeout)
//   idx  6..9  sensor data, LSB first
//   idx 10..11 CRC, low byte first
//
// A one-deep buffer holds a request that arrives while a frame is in
// progress. A request that finds the buffer full is discarded and flagged
// on cmd_drop.
//
// Optional feature: define TXGEN_CRC_EN to carry CRC-16/MODBUS over bytes
// 0..9 in bytes 10..11. Without it, bytes 10..11 are 8'h00.
//
// Parameters:
//   DEV_ID   device ID sent in the header bytes
//   TIMEOUT  max cycles spent waiting for sen_rd_valid
// Ports:
//   sys_clk       system clock, rising edge
//   sys_rst       asynchronous active-low reset
//   ret_cmd       sensor ID to read, sampled with ret_cmd_flg
//   ret_cmd_flg   one-cycle request pulse
//   sen_rd_req    one-cycle read request to the sensor store
//   sen_rd_id     sensor ID, held from sen_rd_req until data accepted
//   sen_rd_data   sensor value, qualified by sen_rd_valid
//   sen_rd_valid  one-cycle data-valid pulse
//   tx_data       byte to UART TX, held from tx_start until tx_done
//   tx_start      one-cycle pulse, starts one byte
//   tx_done       one-cycle pulse, byte fully shifted out
//   frame_done    one-cycle pulse after the last byte completes
//   cmd_drop      one-cycle pulse when a request is discarded
// -----------------------------------------------------------------------------
module txgen #(
    parameter logic [15:0] DEV_ID  = 16'h0001,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  ret_cmd,
    input  logic        ret_cmd_flg,
    output logic        sen_rd_req,
    output logic [7:0]  sen_rd_id,
    input  logic [31:0] sen_rd_data,
    input  logic        sen_rd_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        frame_done,
    output logic        cmd_drop
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [7:0]  status_r;
    logic [31:0] data_r;
    logic        pend_vld_r;
    logic [7:0]  pend_id_r;
    logic [15:0] tmo_cnt_r;
    logic        sen_rd_req_r;
    logic [7:0]  sen_rd_id_r;
    logic [7:0]  tx_data_r;
    logic        tx_start_r;
    logic        frame_done_r;
    logic        cmd_drop_r;
    logic [15:0] crc_s;

    // Selects the frame byte for a given index from the latched fields.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  id,
        input logic [7:0]  status,
        input logic [31:0] data,
        input logic [15:0] crc
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = DEV_ID[15:8];
            4'd1:    b = DEV_ID[7:0];
            4'd2:    b = 8'h00;
            4'd3:    b = 8'h08;
            4'd4:    b = id;
            4'd5:    b = status;
            4'd6:    b = data[7:0];
            4'd7:    b = data[15:8];
            4'd8:    b = data[23:16];
            4'd9:    b = data[31:24];
            4'd10:   b = crc[7:0];
            4'd11:   b = crc[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef TXGEN_CRC_EN
    logic [15:0] crc_r;

    // One byte step of CRC-16/MODBUS (reflected polynomial 0xA001).
    function automatic logic [15:0] crc16_modbus_byte(
        input logic [15:0] crc_in,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // The CRC restarts with every request. It absorbs each byte in its SEND
    // cycle, so it already covers byte 9 by the time byte 10 is loaded.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            crc_r <= 16'hFFFF;
        end else if (state_r == ST_REQ) begin
            crc_r <= 16'hFFFF;
        end else if ((state_r == ST_SEND) && (idx_r <= 4'd9)) begin
            crc_r <= crc16_modbus_byte(crc_r, tx_data_r);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_s = crc_r;
`else
    assign crc_s = 16'h0000;
`endif

    // Main sequencer: request, data fetch or timeout, then byte handshake.
    // Every output is a register loaded on the transition into its state.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 4'd0;
            status_r     <= 8'h00;
            data_r       <= 32'h0000_0000;
            pend_vld_r   <= 1'b0;
            pend_id_r    <= 8'h00;
            tmo_cnt_r    <= 16'd0;
            sen_rd_req_r <= 1'b0;
            sen_rd_id_r  <= 8'h00;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            cmd_drop_r   <= 1'b0;
        end else begin
            sen_rd_req_r <= 1'b0;
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            cmd_drop_r   <= 1'b0;

            // A request that arrives while busy is parked, or dropped if the
            // park slot is taken. The IDLE branch below handles its own arrivals.
            if ((state_r != ST_IDLE) && ret_cmd_flg) begin
                if (!pend_vld_r) begin
                    pend_vld_r <= 1'b1;
                    pend_id_r  <= ret_cmd;
                end else begin
                    cmd_drop_r <= 1'b1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (pend_vld_r) begin
                        // Older parked request goes first; a simultaneous
                        // new one takes its place in the slot.
                        state_r      <= ST_REQ;
                        sen_rd_req_r <= 1'b1;
                        sen_rd_id_r  <= pend_id_r;
                        tmo_cnt_r    <= 16'd0;
                        if (ret_cmd_flg) begin
                            pend_id_r <= ret_cmd;
                        end else begin
                            pend_vld_r <= 1'b0;
                        end
                    end else if (ret_cmd_flg) begin
                        state_r      <= ST_REQ;
                        sen_rd_req_r <= 1'b1;
                        sen_rd_id_r  <= ret_cmd;
                        tmo_cnt_r    <= 16'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_r <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    // Valid takes priority over a timeout in the same cycle.
                    if (sen_rd_valid) begin
                        data_r     <= sen_rd_data;
                        status_r   <= 8'h03;
                        idx_r      <= 4'd0;
                        tx_data_r  <= DEV_ID[15:8];
                        tx_start_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end else if (tmo_cnt_r == (TIMEOUT - 16'd1)) begin
                        data_r     <= 32'hFFFF_FFFF;
                        status_r   <= 8'hEE;
                        idx_r      <= 4'd0;
                        tx_data_r  <= DEV_ID[15:8];
                        tx_start_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
                ST_SEND: begin
                    state_r <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (idx_r == 4'd11) begin
                            idx_r        <= 4'd0;
                            frame_done_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r      <= idx_r + 4'd1;
                            tx_data_r  <= frame_byte(idx_r + 4'd1, sen_rd_id_r,
                                                     status_r, data_r, crc_s);
                            tx_start_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sen_rd_req = sen_rd_req_r;
    assign sen_rd_id  = sen_rd_id_r;
    assign tx_data    = tx_data_r;
    assign tx_start   = tx_start_r;
    assign frame_done = frame_done_r;
    assign cmd_drop   = cmd_drop_r;

endmodule

// File: tb/tb_txgen.sv
// -----------------------------------------------------------------------------
// tb_txgen - self-checking bench for txgen.
//
// A sensor-store responder and a UART responder (with a random 1..20 cycle
// byte time) run beside the main directed sequence. Expected frames are
// built from the frame layout rules. The CRC expectation follows
// TXGEN_CRC_EN in the same way the design does.
// -----------------------------------------------------------------------------
module tb_txgen;

    localparam int TIMEOUT_CYC = 1000;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  ret_cmd;
    logic        ret_cmd_flg;
    logic        sen_rd_req;
    logic [7:0]  sen_rd_id;
    logic [31:0] sen_rd_data;
    logic        sen_rd_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        frame_done;
    logic        cmd_drop;

    logic        model_valid;
    logic        stray_valid;
    logic [31:0] model_data;
    logic        uart_done;
    logic        stray_done;

    assign sen_rd_valid = model_valid | stray_valid;
    assign sen_rd_data  = model_data;
    assign tx_done      = uart_done | stray_done;

    txgen dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .ret_cmd      (ret_cmd),
        .ret_cmd_flg  (ret_cmd_flg),
        .sen_rd_req   (sen_rd_req),
        .sen_rd_id    (sen_rd_id),
        .sen_rd_data  (sen_rd_data),
        .sen_rd_valid (sen_rd_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .frame_done   (frame_done),
        .cmd_drop     (cmd_drop)
    );

    int unsigned n_cmp;
    int unsigned n_mis;
    int          cyc;
    int          n_start, n_frame, n_drop;
    int          frame_done_cyc, drop_cyc, done_cyc, valid_cyc, flg_cyc;
    int          start_cyc_q[$];
    int          req_cyc_q[$];
    logic [7:0]  req_id_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] sen_mem [256];
    logic        sen_silent;
    int          sen_delay;
    logic        uart_busy;
    int          uart_left;
    logic [7:0]  uart_cur;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pulse counts and cycle stamps.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (tx_start === 1'b1) begin n_start++; start_cyc_q.push_back(cyc); end
            if (frame_done === 1'b1) begin n_frame++; frame_done_cyc = cyc; end
            if (cmd_drop === 1'b1) begin n_drop++; drop_cyc = cyc; end
            if (sen_rd_req === 1'b1) begin
                req_cyc_q.push_back(cyc);
                req_id_q.push_back(sen_rd_id);
            end
        end
    end

    // Sensor store model: answers after sen_delay cycles unless silenced.
    initial begin
        logic [7:0] id;
        model_valid = 1'b0;
        model_data  = 32'h0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst && (sen_rd_req === 1'b1) && !sen_silent) begin
                id = sen_rd_id;
                for (int i = 0; i < sen_delay; i++) begin
                    @(negedge sys_clk);
                    check("sen_rd_id_stable", 32'(sen_rd_id), 32'(id));
                end
                model_data  = sen_mem[id];
                model_valid = 1'b1;
                valid_cyc   = cyc;
                @(negedge sys_clk);
                model_valid = 1'b0;
            end
        end
    end

    // UART model: captures each byte, holds for 1..20 cycles, then pulses done.
    initial begin
        uart_done = 1'b0;
        uart_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            uart_done = 1'b0;
            if (!sys_rst) begin
                uart_busy = 1'b0;
            end else if (uart_busy) begin
                check("tx_data_stable", 32'(tx_data), 32'(uart_cur));
                check("one_start_per_byte", 32'(tx_start), 32'd0);
                uart_left--;
                if (uart_left == 0) begin
                    uart_done = 1'b1;
                    done_cyc  = cyc;
                    uart_busy = 1'b0;
                end
            end else if (tx_start === 1'b1) begin
                uart_cur = tx_data;
                byte_q.push_back(tx_data);
                uart_left = int'($urandom_range(1, 20));
                uart_busy = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic pulse_cmd(input logic [7:0] id);
        ret_cmd     = id;
        ret_cmd_flg = 1'b1;
        flg_cyc     = cyc;
        tick();
        ret_cmd_flg = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while ((n_frame < target) && (n < budget)) begin tick(); n++; end
        check("frame_count", 32'(n_frame), 32'(target));
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while ((n_start < target) && (n < budget)) begin tick(); n++; end
        check("start_reached", (n_start >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        start_cyc_q.delete();
        req_cyc_q.delete();
        req_id_q.delete();
        byte_q.delete();
    endtask

    // Reference frame from the layout rules; compared with the captured bytes.
    task automatic check_frame(input logic [7:0] id, input logic ok, input logic [31:0] d);
        logic [7:0]  f [12];
        logic [31:0] dd;
        logic [15:0] c;
        dd   = ok ? d : 32'hFFFF_FFFF;
        f[0] = 8'h00; f[1] = 8'h01; f[2] = 8'h00; f[3] = 8'h08;
        f[4] = id;
        f[5] = ok ? 8'h03 : 8'hEE;
        for (int i = 0; i < 4; i++) f[6 + i] = dd[8 * i +: 8];
        c = 16'hFFFF;
`ifdef TXGEN_CRC_EN
        for (int i = 0; i < 10; i++) begin
            c = c ^ {8'h00, f[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        f[10] = c[7:0];
        f[11] = c[15:8];
`else
        f[10] = 8'h00;
        f[11] = 8'h00;
`endif
        check("frame_avail", (byte_q.size() >= 12) ? 32'd1 : 32'd0, 32'd1);
        if (byte_q.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                check($sformatf("frame_byte%0d", i), 32'(byte_q.pop_front()), 32'(f[i]));
            end
        end
    endtask

    function automatic int first_of(input int q[$], input int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    initial begin
        int          s0, f0, d0, r0, ld, s1;
        logic [7:0]  rid;

        sys_rst     = 1'b0;
        ret_cmd     = 8'h00;
        ret_cmd_flg = 1'b0;
        stray_done  = 1'b0;
        stray_valid = 1'b0;
        sen_silent  = 1'b0;
        sen_delay   = 3;
        for (int i = 0; i < 256; i++) sen_mem[i] = $urandom;

        // Reset values
        repeat (3) tick();
        check("rst_sen_rd_req", 32'(sen_rd_req), 32'd0);
        check("rst_tx_start",   32'(tx_start),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cmd_drop",   32'(cmd_drop),   32'd0);
        check("rst_sen_rd_id",  32'(sen_rd_id),  32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        sys_rst = 1'b1;
        repeat (3) tick();

        // Basic read: ID 5, data after 3 cycles
        sen_mem[8'h05] = 32'h1234_5678;
        clear_logs();
        s0 = n_start; f0 = n_frame;
        pulse_cmd(8'h05);
        wait_frames(f0 + 1, 1000);
        check("basic_req_cycle", 32'(first_of(req_cyc_q, 0)), 32'(flg_cyc + 1));
        check("basic_req_id", (req_id_q.size() > 0) ? 32'(req_id_q[0]) : 32'hFFFF, 32'h05);
        check("basic_first_start", 32'(first_of(start_cyc_q, 0)), 32'(valid_cyc + 1));
        check("basic_frame_done_cycle", 32'(frame_done_cyc), 32'(done_cyc + 1));
        check("basic_start_count", 32'(n_start - s0), 32'd12);
        check_frame(8'h05, 1'b1, 32'h1234_5678);

        // Timeout: store never answers
        repeat (5) tick();
        clear_logs();
        sen_silent = 1'b1;
        f0 = n_frame;
        pulse_cmd(8'h05);
        wait_frames(f0 + 1, TIMEOUT_CYC + 1000);
        check("tmo_first_start", 32'(first_of(start_cyc_q, 0)),
              32'(first_of(req_cyc_q, 0) + TIMEOUT_CYC + 1));
        check_frame(8'h05, 1'b0, 32'h0);
        sen_silent = 1'b0;

        // Back-to-back: ID 7 parked mid-frame
        repeat (5) tick();
        clear_logs();
        sen_delay = int'($urandom_range(1, 8));
        s0 = n_start; f0 = n_frame;
        pulse_cmd(8'h09);
        wait_starts(s0 + 3, 500);
        pulse_cmd(8'h07);
        wait_frames(f0 + 1, 1000);
        ld = done_cyc;
        check("b2b_frame_done_cycle", 32'(frame_done_cyc), 32'(ld + 1));
        wait_frames(f0 + 2, 1000);
        check("b2b_req2_cycle", 32'(first_of(req_cyc_q, 1)), 32'(ld + 2));
        check("b2b_req2_id", (req_id_q.size() > 1) ? 32'(req_id_q[1]) : 32'hFFFF, 32'h07);
        check_frame(8'h09, 1'b1, sen_mem[8'h09]);
        check_frame(8'h07, 1'b1, sen_mem[8'h07]);

        // Overflow: one parked, the next one dropped
        repeat (5) tick();
        clear_logs();
        s0 = n_start; f0 = n_frame; d0 = n_drop;
        pulse_cmd(8'h21);
        wait_starts(s0 + 2, 500);
        pulse_cmd(8'h22);
        wait_starts(s0 + 5, 500);
        pulse_cmd(8'h23);
        repeat (3) tick();
        check("ovf_drop_count", 32'(n_drop - d0), 32'd1);
        check("ovf_drop_cycle", 32'(drop_cyc), 32'(flg_cyc + 1));
        wait_frames(f0 + 2, 2000);
        repeat (60) tick();
        check("ovf_two_frames", 32'(n_frame), 32'(f0 + 2));
        check("ovf_req_count", 32'(req_id_q.size()), 32'd2);
        check_frame(8'h21, 1'b1, sen_mem[8'h21]);
        check_frame(8'h22, 1'b1, sen_mem[8'h22]);

        // Stray tx_done / sen_rd_valid while idle
        clear_logs();
        s0 = n_start; f0 = n_frame; r0 = req_cyc_q.size();
        for (int i = 0; i < 20; i++) begin
            stray_done  = 1'($urandom_range(0, 1));
            stray_valid = 1'($urandom_range(0, 1));
            tick();
        end
        stray_done  = 1'b0;
        stray_valid = 1'b0;
        repeat (3) tick();
        check("stray_no_start", 32'(n_start), 32'(s0));
        check("stray_no_req",   32'(req_cyc_q.size()), 32'(r0));
        check("stray_no_frame", 32'(n_frame), 32'(f0));

        // Randomised IDs, data and store latency
        for (int k = 0; k < 4; k++) begin
            clear_logs();
            rid          = 8'($urandom);
            sen_mem[rid] = $urandom;
            sen_delay    = int'($urandom_range(1, 10));
            f0 = n_frame;
            pulse_cmd(rid);
            wait_frames(f0 + 1, 1000);
            check_frame(rid, 1'b1, sen_mem[rid]);
        end

        // Reset during byte 6
        repeat (5) tick();
        clear_logs();
        s0 = n_start; f0 = n_frame;
        sen_delay = 2;
        pulse_cmd(8'h33);
        wait_starts(s0 + 7, 500);
        tick();
        sys_rst = 1'b0;
        #1;
        check("mid_rst_sen_rd_req", 32'(sen_rd_req), 32'd0);
        check("mid_rst_tx_start",   32'(tx_start),   32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_cmd_drop",   32'(cmd_drop),   32'd0);
        check("mid_rst_sen_rd_id",  32'(sen_rd_id),  32'd0);
        check("mid_rst_tx_data",    32'(tx_data),    32'd0);
        repeat (3) tick();
        sys_rst = 1'b1;
        s1 = n_start;
        repeat (40) tick();
        check("post_rst_no_start", 32'(n_start), 32'(s1));
        check("post_rst_no_frame", 32'(n_frame), 32'(f0));
        clear_logs();
        sen_mem[8'h34] = $urandom;
        pulse_cmd(8'h34);
        wait_frames(f0 + 1, 1000);
        check_frame(8'h34, 1'b1, sen_mem[8'h34]);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
